// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: HI/LO multiply/divide sequencer (shift-add MUL, restoring DIV, MTHI/MTLO).
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle combinational MULT/MULTU.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_req,
    output logic [63:0] result,
    output logic        hi_en,
    output logic        lo_en,
    output logic        busy,
    output logic        stall
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] m_q, m_d;
    logic [63:0] acc_q, acc_d;
    logic        res_neg_q, res_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        div0_q, div0_d;
    logic [63:0] result_q, result_d;

    logic        in_mult, in_div, in_move, in_valid, in_signed;
    logic [31:0] in_mag_a, in_mag_b;

    always_comb begin
        in_mult   = (op == OP_MULT) || (op == OP_MULTU);
        in_div    = (op == OP_DIV)  || (op == OP_DIVU);
        in_move   = (op == OP_MTHI) || (op == OP_MTLO);
        in_valid  = in_mult || in_div || in_move;
        in_signed = (op == OP_MULT) || (op == OP_DIV);
        // 0x80000000 negates to itself, which read unsigned is exactly 2^31
        in_mag_a  = (in_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
        in_mag_b  = (in_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
    end

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] mul_fix;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [31:0] quo_fix, rem_fix;

    // acc holds {hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
        mul_fix  = res_neg_q ? (~mul_next + 64'd1) : mul_next;
        div_diff = acc_q[63:31] - {1'b0, m_q};
        if (!div_diff[32]) begin
            div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            div_next = {acc_q[62:31], acc_q[30:0], 1'b0};
        end
        quo_fix = res_neg_q ? (~div_next[31:0] + 32'd1) : div_next[31:0];
        rem_fix = rem_neg_q ? (~div_next[63:32] + 32'd1) : div_next[63:32];
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_a, fast_b, fast_prod;

    always_comb begin
        fast_a    = (op == OP_MULT) ? {{32{rs_val[31]}}, rs_val} : {32'b0, rs_val};
        fast_b    = (op == OP_MULT) ? {{32{rt_val[31]}}, rt_val} : {32'b0, rt_val};
        fast_prod = fast_a * fast_b;
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        m_d       = m_q;
        acc_d     = acc_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        result_d  = result_q;
        if (!waitrequest) begin
            case (state_q)
                ST_IDLE: begin
                    if (start && in_valid) begin
                        op_d      = op;
                        a_d       = rs_val;
                        cnt_d     = '0;
                        res_neg_d = in_signed && (rs_val[31] ^ rt_val[31]);
                        rem_neg_d = in_signed && rs_val[31];
                        div0_d    = (rt_val == '0);
                        if (in_move) begin
                            result_d = {32'b0, rs_val};
                            state_d  = ST_DONE;
                        end else if (in_mult) begin
`ifdef MULDIV_FAST_MUL_EN
                            result_d = fast_prod;
                            state_d  = ST_DONE;
`else
                            m_d     = in_mag_a;
                            acc_d   = {32'b0, in_mag_b};
                            state_d = ST_MUL;
`endif
                        end else begin
                            m_d     = in_mag_b;
                            acc_d   = {32'b0, in_mag_a};
                            state_d = ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_d = mul_fix;
                        state_d  = ST_DONE;
                    end
                end
                ST_DIV: begin
                    acc_d = div_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_d = div0_q ? {a_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        result = result_q;
        busy   = (state_q != ST_IDLE);
        stall  = busy && (start || mf_req);
        hi_en  = (state_q == ST_DONE) && !waitrequest && (op_q != OP_MTLO);
        lo_en  = (state_q == ST_DONE) && !waitrequest && (op_q != OP_MTHI);
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + randomized bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset, waitrequest, start, mf_req;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic [63:0] result;
    logic        hi_en, lo_en, busy, stall;

    int n_cmp = 0;
    int n_err = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .waitrequest(waitrequest), .start(start),
        .op(op), .rs_val(rs_val), .rt_val(rt_val), .mf_req(mf_req),
        .result(result), .hi_en(hi_en), .lo_en(lo_en), .busy(busy), .stall(stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: return 64'(sa * sb);
            3'd1: return {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return {32'b0, a};
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] o);
        if (o <= 3'd1) return MUL_LAT;
        if (o <= 3'd3) return 33;
        return 1;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Call right after the accepting edge; counts cycles to the strobe and checks it.
    task automatic run_and_check(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input int wr_at, input int wr_len, input string tag);
        logic [63:0] exp;
        int lat;
        logic got, seq_ok;
        exp = model(o, a, b);
        lat = 0; got = 1'b0; seq_ok = 1'b1;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (wr_len > 0 && lat == wr_at) waitrequest = 1'b1;
            if (wr_len > 0 && lat == wr_at + wr_len) waitrequest = 1'b0;
            #1;
            if (hi_en || lo_en) got = 1'b1;
            else if (busy !== 1'b1 || stall !== (start | mf_req)) seq_ok = 1'b0;
        end
        waitrequest = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(exp_latency(o) + wr_len));
        chk({tag, "_strobes"}, {62'b0, hi_en, lo_en}, {62'b0, o != 3'd5, o != 3'd4});
        if (o >= 3'd4) chk({tag, "_move"}, {32'b0, result[31:0]}, {32'b0, exp[31:0]});
        else chk({tag, "_result"}, result, exp);
        chk({tag, "_stall_done"}, {63'b0, stall}, {63'b0, start | mf_req});
        chk({tag, "_busy_stall_seq"}, {63'b0, seq_ok}, 64'd1);
        @(negedge clk);
        #1;
        chk({tag, "_after"}, {61'b0, hi_en, lo_en, busy}, 64'd0);
        chk({tag, "_after_stall"}, {63'b0, stall}, 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int wa, wl;
        logic seen;

        reset = 1'b1; waitrequest = 1'b0; start = 1'b0; mf_req = 1'b0;
        op = '0; rs_val = '0; rt_val = '0;
        #3;
        chk("reset_result", result, 64'd0);
        chk("reset_flags", {60'b0, hi_en, lo_en, busy, stall}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        run_and_check(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, "mult_neg2x3");
        chk("mult_neg2x3_value", result, 64'hFFFF_FFFF_FFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_and_check(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_m7_2");
        chk("div_m7_2_value", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        issue(3'd3, 32'd7, 32'd0);
        run_and_check(3'd3, 32'd7, 32'd0, 0, 0, "divu_by0");
        chk("divu_by0_value", result, {32'h0000_0007, 32'hFFFF_FFFF});

        issue(3'd4, 32'h1234_5678, 32'd0);
        run_and_check(3'd4, 32'h1234_5678, 32'd0, 0, 0, "mthi");

        issue(3'd0, 32'd1000, 32'hFFFF_FF00);
        mf_req = 1'b1;
        run_and_check(3'd0, 32'd1000, 32'hFFFF_FF00, 0, 0, "mult_mfreq");
        mf_req = 1'b0;

        issue(3'd2, 32'h8000_0000, 32'd7);
        run_and_check(3'd2, 32'h8000_0000, 32'd7, 10, 5, "div_wait5");

        issue(3'd5, 32'hA5A5_0F0F, 32'd0);
        run_and_check(3'd5, 32'hA5A5_0F0F, 32'd0, 1, 4, "mtlo_wait_done");

        // start held during an op: stalled until IDLE, then accepted one cycle later
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        start = 1'b1; op = 3'd4; rs_val = 32'hCAFE_F00D; rt_val = 32'd9;
        run_and_check(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_held_start");
        @(posedge clk);
        #1 start = 1'b0;
        run_and_check(3'd4, 32'hCAFE_F00D, 32'd9, 0, 0, "chained_mthi");

        @(negedge clk);
        start = 1'b1; op = 3'd6;
        @(posedge clk);
        #1 start = 1'b0;
        chk("invalid_op_idle", {63'b0, busy}, 64'd0);

        issue(3'd0, 32'd12345, 32'd678);
        repeat (9) @(negedge clk);
        #1 chk("pre_reset_busy", {63'b0, busy}, 64'd1);
        mf_req = 1'b1;
        #1 chk("pre_reset_stall", {63'b0, stall}, 64'd1);
        reset = 1'b1;
        #1;
        chk("midop_reset_result", result, 64'd0);
        chk("midop_reset_flags", {60'b0, hi_en, lo_en, busy, stall}, 64'd0);
        mf_req = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (hi_en || lo_en) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1 if (hi_en || lo_en || busy) seen = 1'b1;
        end
        chk("reset_no_strobe", {63'b0, seen}, 64'd0);
        issue(3'd1, 32'd2, 32'd3);
        run_and_check(3'd1, 32'd2, 32'd3, 0, 0, "multu_2x3");
        chk("multu_2x3_value", result, 64'd6);

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = rnd_operand();
            rb = rnd_operand();
            if (ro > 3'd5) begin
                @(negedge clk);
                start = 1'b1; op = ro;
                @(posedge clk);
                #1 start = 1'b0;
                chk("rand_invalid_idle", {63'b0, busy}, 64'd0);
            end else begin
                wa = 0; wl = 0;
                if ((ro == 3'd2 || ro == 3'd3) && $urandom_range(0, 1) == 1) begin
                    wa = $urandom_range(1, 25);
                    wl = $urandom_range(1, 4);
                end
                mf_req = 1'($urandom_range(0, 1));
                issue(ro, ra, rb);
                run_and_check(ro, ra, rb, wa, wl, $sformatf("rand%0d_op%0d", i, ro));
                mf_req = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL provide these ports, in order:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- waitrequest  in  1  memory stall; 1 freezes the block
- start  in  1  EX-stage request to issue an op
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others no-op
- rs_val  in  32  operand A / dividend / move source
- rt_val  in  32  operand B / divisor
- mf_req  in  1  EX stage needs HI/LO (MFHI/MFLO in flight)
- result  out  64  {hi,lo} for mult/div; move value in [31:0]
- hi_en  out  1  HI write strobe
- lo_en  out  1  LO write strobe
- busy  out  1  op in progress
- stall  out  1  pipeline hold request

Function
REQ-003 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-004 In IDLE with start=1, waitrequest=0 and a valid op, the block SHALL latch operands and op and leave IDLE on that edge.
- Mult ops go to MUL, div ops go to DIV, MTHI/MTLO go to DONE.
- With start=1 and an invalid op, the block SHALL stay in IDLE.
REQ-005 MUL and DIV SHALL each run exactly 32 iteration cycles with a 6-bit counter, then enter DONE.
- MUL is shift-add on magnitudes.
- DIV is restoring division on magnitudes.
REQ-006 Signed ops SHALL operate on absolute values.
- Product sign = sign(A) XOR sign(B).
- Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- Sign is applied when forming result in DONE.
- 0x80000000 magnitude SHALL be handled as unsigned 2^31.
REQ-007 Division by zero SHALL complete in the normal 32+1 cycles with result = {rs_val, 32'hFFFFFFFF}.
REQ-008 result SHALL be valid in DONE; for mult it is the 64-bit product; for div hi = remainder, lo = quotient.
REQ-009 In DONE with waitrequest=0, the strobes SHALL pulse for exactly one cycle and the FSM SHALL return to IDLE:
- mult/div: hi_en=lo_en=1
- MTHI: hi_en=1, lo_en=0, result[31:0]=rs_val
- MTLO: lo_en=1, hi_en=0, result[31:0]=rs_val
REQ-010 hi_en and lo_en SHALL be 0 in all states other than DONE, and 0 whenever waitrequest=1.
REQ-011 While waitrequest=1, state, counter and operand registers SHALL hold and result SHALL hold its value.
REQ-012 busy SHALL be 1 in MUL, DIV and DONE, and 0 in IDLE.
REQ-013 stall SHALL equal busy AND (start OR mf_req); it is combinational, with no added cycle.
REQ-014 A start arriving while busy=1 SHALL be ignored, and stall SHALL hold it in EX until IDLE.
- start and DONE-exit in the same cycle SHALL stall; the op is accepted the next cycle.
REQ-015 Latency from the accepting edge to the hi_en pulse (waitrequest=0 throughout):
- MULT/DIV/DIVU/MULTU: 33 cycles
- MTHI/MTLO: 1 cycle

Reset
REQ-016 On reset=1, asynchronously and regardless of clk:
- state=IDLE, counter=0
- result=0, hi_en=lo_en=busy=stall=0
REQ-017 Reset mid-operation SHALL abandon the op with no strobe issued; the first op after release SHALL behave as from power-up.

Configuration
REQ-018 Macro MULDIV_FAST_MUL_EN:
- Defined: MULT/MULTU SHALL use a single-cycle combinational 32x32 multiply and go IDLE->DONE, with latency 1.
- Undefined: the iterative 32-cycle MUL state SHALL be used.
- DIV behaviour SHALL be identical in both builds.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- MULT rs=0xFFFFFFFE(-2), rt=3 -> after 33 cycles hi_en=lo_en=1, result=0xFFFFFFFF_FFFFFFFA; with MULDIV_FAST_MUL_EN, after 1 cycle.
- DIV rs=-7, rt=2 -> after 33 cycles result={0xFFFFFFFF,0xFFFFFFFD}; DIVU rs=7, rt=0 -> result={0x00000007,0xFFFFFFFF}.
- MTHI rs=0x12345678 -> next cycle hi_en=1, lo_en=0, result[31:0]=0x12345678, busy never 1 after the strobe.
- mf_req=1 during MULT -> stall=1 until the DONE-exit cycle; hi_en pulses once; stall=0 in the following IDLE cycle.
- waitrequest=1 for 5 cycles mid-DIV -> completion delayed exactly 5 cycles, same result; waitrequest=1 in DONE -> strobe deferred, single pulse.
- reset pulsed at cycle 10 of MULT -> all outputs 0 immediately; no strobe; next MULTU 2x3 -> result=6.
